// File: rtl/nor_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nor_share_arbiter
//  Description : Four requesters share one 2-input NOR evaluator. A round-
//                robin arbiter grants one requester, the NOR result is
//                captured one cycle later, and the grant is retired after a
//                further cycle. Gives at most one evaluation every 3 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module nor_share_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       y,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] C_ONE = 4'b0001;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] win_q;
  logic [3:0] gnt_q;
  logic [3:0] done_q;
  logic       y_q;
  logic [7:0] cnt_q;

  logic [1:0] win_d;
  logic [1:0] idx_d;

  // Round-robin pick: the lowest offset from ptr with an active request wins.
  // Scanning from the highest offset down lets the closest requester overwrite.
  always_comb begin
    win_d = ptr_q;
    idx_d = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx_d = ptr_q + 2'(k);
      if (req[idx_d]) begin
        win_d = idx_d;
      end
    end
  end

  // Arbitration / evaluation FSM; every output is held in a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      y_q     <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            gnt_q   <= C_ONE << win_d;
            state_q <= S_GRANT;
          end else begin
            gnt_q <= 4'b0000;
          end
        end
        S_GRANT: begin
          // Operands are sampled only here; the grant is committed even if
          // the requester has already dropped req.
          y_q     <= ~(a[win_q] | b[win_q]);
          done_q  <= C_ONE << win_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 4'b0000;
          gnt_q   <= 4'b0000;
          ptr_q   <= win_q + 2'd1;
          cnt_q   <= cnt_q + 8'd1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 4'b0000;
          gnt_q   <= 4'b0000;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are straight register copies; busy decodes the state register.
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign y        = y_q;
  assign op_count = cnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
